// File: rtl/e_cpu_io_cfg_switch_matrix.sv
// ---------------------------------------------------------------------------
// e_cpu_io_cfg_switch_matrix
//
// Runtime-configurable east-edge CPU-IO switch matrix. Each of NUM_OUT
// outputs is a mux over NUM_IN source wires plus a constant 0. The mux
// selectors are loaded serially into a shadow register and copied
// atomically into the active register on commit, so the routing changes in
// a single cycle rather than bit by bit.
//
// Ports:
//   UserCLK       clock, all state updates on the rising edge
//   RESET         asynchronous active-high reset
//   in_i          source wires (tile E6END*/OPx_O* side)
//   out_o         mux outputs (CPU-IO RES*_I* side)
//   cfg_data_i    serial configuration bit
//   cfg_shift_i   shift cfg_data_i into the shadow register
//   cfg_commit_i  copy shadow into active (only legal once shadow is full)
//   cfg_clear_i   abort a load: clear shadow, bit counter and error flag
//   cfg_done_o    one-cycle pulse after a successful commit
//   cfg_full_o    shadow holds exactly CFG_BITS freshly shifted bits
//   cfg_err_o     sticky protocol error, cleared by cfg_clear_i or RESET
//
// Selector encoding per output j (sel = active[j*SEL_W +: SEL_W]):
//   0 -> constant 0, 1..NUM_IN -> in_i[sel-1], above NUM_IN -> constant 0.
//
// Build option:
//   E_CPU_IO_CFG_SW_REG_OUT_EN  when defined, out_o is registered on UserCLK
//                               (one extra cycle of in_i -> out_o latency).
// ---------------------------------------------------------------------------
module e_cpu_io_cfg_switch_matrix #(
    parameter int unsigned NUM_IN  = 16,
    parameter int unsigned NUM_OUT = 12
) (
    input  logic               UserCLK,
    input  logic               RESET,
    input  logic [NUM_IN-1:0]  in_i,
    output logic [NUM_OUT-1:0] out_o,
    input  logic               cfg_data_i,
    input  logic               cfg_shift_i,
    input  logic               cfg_commit_i,
    input  logic               cfg_clear_i,
    output logic               cfg_done_o,
    output logic               cfg_full_o,
    output logic               cfg_err_o
);

    // Derived widths, kept local so they cannot be overridden inconsistently.
    localparam int unsigned SEL_W    = $clog2(NUM_IN + 1);
    localparam int unsigned CFG_BITS = NUM_OUT * SEL_W;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          state_q, state_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [CNT_W-1:0]    cnt_inc;
    logic [NUM_OUT-1:0]  mux_out;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Priority: clear > commit > shift.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        err_d    = err_q;
        done_d   = 1'b0;

        if (cfg_clear_i) begin
            shadow_d = '0;
            cnt_d    = '0;
            state_d  = ST_IDLE;
            err_d    = 1'b0;
        end else if (cfg_commit_i) begin
            // A simultaneous shift is dropped and flagged.
            if (cfg_shift_i) begin
                err_d = 1'b1;
            end
            if (state_q == ST_FULL) begin
                active_d = shadow_q;
                cnt_d    = '0;
                state_d  = ST_IDLE;
                done_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else if (cfg_shift_i) begin
            // First bit shifted in ends up in the MSB.
            shadow_d = CFG_BITS'({shadow_q, cfg_data_i});
            if (state_q == ST_FULL) begin
                // Overrun: keep shifting, hold the counter, flag it.
                err_d = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == CNT_W'(CFG_BITS)) ? ST_FULL : ST_LOAD;
            end
        end
    end

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Compare against every legal code instead of indexing in_i with the
    // selector, so out-of-range codes fall through to 0 naturally.
    always_comb begin
        mux_out = '0;
        for (int unsigned j = 0; j < NUM_OUT; j++) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (active_q[j*SEL_W +: SEL_W] == SEL_W'(k + 1)) begin
                    mux_out[j] = in_i[k];
                end
            end
        end
    end

`ifdef E_CPU_IO_CFG_SW_REG_OUT_EN
    logic [NUM_OUT-1:0] out_q;

    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            out_q <= '0;
        end else begin
            out_q <= mux_out;
        end
    end

    assign out_o = out_q;
`else
    assign out_o = mux_out;
`endif

    assign cfg_done_o = done_q;
    assign cfg_full_o = (state_q == ST_FULL);
    assign cfg_err_o  = err_q;

endmodule

// File: tb/tb_e_cpu_io_cfg_switch_matrix.sv
// ---------------------------------------------------------------------------
// Self-checking bench for e_cpu_io_cfg_switch_matrix (NUM_IN=16, NUM_OUT=12).
// Expected out_o values are computed from a bench-side copy of the active
// configuration, queued when in_i is driven and popped when out_o is sampled.
// ---------------------------------------------------------------------------
module tb_e_cpu_io_cfg_switch_matrix;

    localparam int NUM_IN   = 16;
    localparam int NUM_OUT  = 12;
    localparam int SEL_W    = 5;
    localparam int CFG_BITS = 60;

`ifdef E_CPU_IO_CFG_SW_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic                UserCLK;
    logic                RESET;
    logic [NUM_IN-1:0]   in_i;
    logic [NUM_OUT-1:0]  out_o;
    logic                cfg_data_i;
    logic                cfg_shift_i;
    logic                cfg_commit_i;
    logic                cfg_clear_i;
    logic                cfg_done_o;
    logic                cfg_full_o;
    logic                cfg_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NUM_OUT-1:0]  exp_q[$];
    logic [CFG_BITS-1:0] model_act;
    logic [CFG_BITS-1:0] w1, w4, w5;

    e_cpu_io_cfg_switch_matrix #(
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .UserCLK      (UserCLK),
        .RESET        (RESET),
        .in_i         (in_i),
        .out_o        (out_o),
        .cfg_data_i   (cfg_data_i),
        .cfg_shift_i  (cfg_shift_i),
        .cfg_commit_i (cfg_commit_i),
        .cfg_clear_i  (cfg_clear_i),
        .cfg_done_o   (cfg_done_o),
        .cfg_full_o   (cfg_full_o),
        .cfg_err_o    (cfg_err_o)
    );

    initial UserCLK = 1'b0;
    always #5 UserCLK = ~UserCLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_OUT-1:0] model_out(input logic [NUM_IN-1:0] in,
                                                       input logic [CFG_BITS-1:0] act);
        logic [NUM_OUT-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            s = int'(act[j*SEL_W +: SEL_W]);
            if (s >= 1 && s <= NUM_IN) r[j] = in[s-1];
        end
        return r;
    endfunction

    // One configuration cycle: drive after the falling edge, sample 1ns after the rising edge.
    task automatic cfg_cycle(input logic sh, input logic d, input logic cm, input logic cl);
        @(negedge UserCLK);
        cfg_shift_i  = sh;
        cfg_data_i   = d;
        cfg_commit_i = cm;
        cfg_clear_i  = cl;
        @(posedge UserCLK);
        #1;
        cfg_shift_i  = 1'b0;
        cfg_data_i   = 1'b0;
        cfg_commit_i = 1'b0;
        cfg_clear_i  = 1'b0;
    endtask

    // Shift the low nbits of word, most significant first.
    task automatic shift_word(input logic [CFG_BITS-1:0] word, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            cfg_cycle(1'b1, word[i], 1'b0, 1'b0);
        end
    endtask

    task automatic drive_and_check(input logic [NUM_IN-1:0] in, input string tag);
        in_i = in;
        exp_q.push_back(model_out(in, model_act));
        if (REG_OUT) begin
            @(posedge UserCLK);
        end
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            check_eq(tag, 64'(out_o), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic check_routing(input string tag);
        for (int k = 0; k < NUM_IN; k++) begin
            drive_and_check(NUM_IN'(1) << k, $sformatf("%s_walk%0d", tag, k));
        end
        drive_and_check('1, {tag, "_ones"});
        drive_and_check('0, {tag, "_zeros"});
        drive_and_check(NUM_IN'($urandom), {tag, "_rand"});
    endtask

    initial begin
        for (int j = 0; j < NUM_OUT; j++) begin
            w1[j*SEL_W +: SEL_W] = SEL_W'(j + 1);
            w5[j*SEL_W +: SEL_W] = SEL_W'(((j * 7) % 16) + 1);
            if (j < 10)       w4[j*SEL_W +: SEL_W] = SEL_W'(16 - j);
            else if (j == 10) w4[j*SEL_W +: SEL_W] = SEL_W'(0);
            else              w4[j*SEL_W +: SEL_W] = SEL_W'(31);
        end
        model_act    = '0;
        RESET        = 1'b1;
        in_i         = '1;
        cfg_data_i   = 1'b0;
        cfg_shift_i  = 1'b0;
        cfg_commit_i = 1'b0;
        cfg_clear_i  = 1'b0;

        // Test 1: reset state with all inputs high.
        repeat (3) @(posedge UserCLK);
        #1;
        check_eq("rst_out", 64'(out_o), 64'h0);
        @(negedge UserCLK);
        RESET = 1'b0;
        @(posedge UserCLK);
        #1;
        check_eq("t1_out", 64'(out_o), 64'h0);
        check_eq("t1_done", 64'(cfg_done_o), 64'h0);
        check_eq("t1_full", 64'(cfg_full_o), 64'h0);
        check_eq("t1_err", 64'(cfg_err_o), 64'h0);
        drive_and_check('1, "t1_ones");

        // Test 2: identity routing sel_j = j+1.
        shift_word(w1, CFG_BITS);
        check_eq("t2_full", 64'(cfg_full_o), 64'h1);
        check_eq("t2_err_pre", 64'(cfg_err_o), 64'h0);
        in_i = '1;
        cfg_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        model_act = w1;
        check_eq("t2_done", 64'(cfg_done_o), 64'h1);
        check_eq("t2_full_post", 64'(cfg_full_o), 64'h0);
        check_eq("t2_out_edge", 64'(out_o), REG_OUT ? 64'h0 : 64'hFFF);
        @(posedge UserCLK);
        #1;
        check_eq("t2_done_gone", 64'(cfg_done_o), 64'h0);
        check_eq("t2_out_next", 64'(out_o), 64'hFFF);
        check_routing("t2");

        // Test 3: premature commit is ignored and flagged; clear restarts the count.
        shift_word({CFG_BITS{1'b1}}, 30);
        cfg_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("t3_err", 64'(cfg_err_o), 64'h1);
        check_eq("t3_full", 64'(cfg_full_o), 64'h0);
        check_eq("t3_done", 64'(cfg_done_o), 64'h0);
        check_routing("t3");
        cfg_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_err_clr", 64'(cfg_err_o), 64'h0);
        check_eq("t3_full_clr", 64'(cfg_full_o), 64'h0);
        shift_word(w4, CFG_BITS - 1);
        check_eq("t3_full_59", 64'(cfg_full_o), 64'h0);
        shift_word(w4, 1);
        check_eq("t3_full_60", 64'(cfg_full_o), 64'h1);
        check_eq("t3_err_60", 64'(cfg_err_o), 64'h0);
        cfg_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t3_full_clr2", 64'(cfg_full_o), 64'h0);

        // Test 4: 61-bit overrun keeps only the last 60 bits.
        cfg_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        shift_word(w4, CFG_BITS);
        check_eq("t4_full", 64'(cfg_full_o), 64'h1);
        check_eq("t4_err", 64'(cfg_err_o), 64'h1);
        cfg_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        model_act = w4;
        check_eq("t4_done", 64'(cfg_done_o), 64'h1);
        check_eq("t4_err_sticky", 64'(cfg_err_o), 64'h1);
        check_routing("t4");
        cfg_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Test 5: shift together with commit in FULL.
        shift_word(w5, CFG_BITS);
        check_eq("t5_err_pre", 64'(cfg_err_o), 64'h0);
        cfg_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        model_act = w5;
        check_eq("t5_done", 64'(cfg_done_o), 64'h1);
        check_eq("t5_err", 64'(cfg_err_o), 64'h1);
        check_eq("t5_full", 64'(cfg_full_o), 64'h0);
        check_routing("t5");

        // Test 6: asynchronous reset mid-load, then a fresh load.
        shift_word(w1, 25);
        in_i = '1;
        #2;
        RESET = 1'b1;
        #1;
        model_act = '0;
        check_eq("t6_out", 64'(out_o), 64'h0);
        check_eq("t6_err", 64'(cfg_err_o), 64'h0);
        check_eq("t6_full", 64'(cfg_full_o), 64'h0);
        check_eq("t6_done", 64'(cfg_done_o), 64'h0);
        @(negedge UserCLK);
        RESET = 1'b0;
        drive_and_check('1, "t6_ones_rst");
        shift_word(w1, CFG_BITS);
        check_eq("t6_full_load", 64'(cfg_full_o), 64'h1);
        cfg_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        model_act = w1;
        check_eq("t6_commit_done", 64'(cfg_done_o), 64'h1);
        check_eq("t6_commit_err", 64'(cfg_err_o), 64'h0);
        check_routing("t6");

        check_eq("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
